// File: rtl/bp_pkg.sv
// Shared types for the branch target predictor: counter encodings and FSM states.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

endpackage

// File: rtl/sat_counter_next.sv
// Next value of a 2-bit saturating direction counter given the resolved outcome.
module sat_counter_next
    import bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Branch target buffer: combinational lookup for fetch, training from execute,
// and a one-entry-per-cycle invalidate sequence.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int XLEN    = 32,
    parameter int IDX_LSB = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] pcF_i,
    input  logic [XLEN-1:0] pcE_i,
    input  logic            update_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] dirsaltoE_i,
    input  logic            desactivar_bp_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] dirobjetivoF_o,
    output logic [1:0]      prediccion_o,
    output logic            hit_o,
    output logic            sel_mux_pred_o,
    output logic            busy_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_LSB - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];
    ctr_t               ctr_d    [ENTRIES];

    bp_state_t          state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   idx_f, idx_e;
    logic [TAG_W-1:0]   tag_f, tag_e;
    logic               hit_e, upd_en;
    ctr_t               ctr_next_e;

    assign idx_f = pcF_i[IDX_LSB +: IDX_W];
    assign tag_f = pcF_i[XLEN-1 -: TAG_W];
    assign idx_e = pcE_i[IDX_LSB +: IDX_W];
    assign tag_e = pcE_i[XLEN-1 -: TAG_W];

    // Lookup reads only registered state, so same-cycle updates are not bypassed.
    assign hit_o          = valid_q[idx_f] && (tag_q[idx_f] == tag_f) && (state_q == IDLE);
    assign prediccion_o   = hit_o ? ctr_q[idx_f] : SNT;
    assign dirobjetivoF_o = target_q[idx_f];
    assign sel_mux_pred_o = hit_o && prediccion_o[1] && !desactivar_bp_i;
    assign busy_o         = (state_q == FLUSH);

    assign hit_e  = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign upd_en = update_i && !desactivar_bp_i && (state_q == IDLE);

    sat_counter_next u_sat_e (
        .ctr_i   (ctr_q[idx_e]),
        .taken_i (branch_taken_i),
        .ctr_o   (ctr_next_e)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                valid_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (upd_en) begin
            if (hit_e) begin
                ctr_d[idx_e] = ctr_next_e;
                if (branch_taken_i) target_d[idx_e] = dirsaltoE_i;
            end else if (branch_taken_i) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = dirsaltoE_i;
                ctr_d[idx_e]    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scenario bench for branch_target_predictor: expected lookup results are queued
// as stimulus is driven and compared when the outputs are sampled.
module tb_branch_target_predictor;

    localparam int XLEN = 32;
    localparam int W    = XLEN + 5;

    logic            clk_i;
    logic            reset_i;
    logic [XLEN-1:0] pcF_i;
    logic [XLEN-1:0] pcE_i;
    logic            update_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] dirsaltoE_i;
    logic            desactivar_bp_i;
    logic            flush_i;
    logic [XLEN-1:0] dirobjetivoF_o;
    logic [1:0]      prediccion_o;
    logic            hit_o;
    logic            sel_mux_pred_o;
    logic            busy_o;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;
    logic [W-1:0] exp_v;
    int n_checks;
    int n_fail;

    branch_target_predictor #(.ENTRIES(32), .XLEN(XLEN), .IDX_LSB(2)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .pcF_i           (pcF_i),
        .pcE_i           (pcE_i),
        .update_i        (update_i),
        .branch_taken_i  (branch_taken_i),
        .dirsaltoE_i     (dirsaltoE_i),
        .desactivar_bp_i (desactivar_bp_i),
        .flush_i         (flush_i),
        .dirobjetivoF_o  (dirobjetivoF_o),
        .prediccion_o    (prediccion_o),
        .hit_o           (hit_o),
        .sel_mux_pred_o  (sel_mux_pred_o),
        .busy_o          (busy_o)
    );

    // clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] mk(input logic busy, input logic hit, input logic [1:0] pred,
                                        input logic sel, input logic [XLEN-1:0] tgt);
        return {busy, hit, pred, sel, tgt};
    endfunction

    function automatic logic [W-1:0] observe();
        return {busy_o, hit_o, prediccion_o, sel_mux_pred_o, dirobjetivoF_o};
    endfunction

    // Drivers: called at posedge+1; inputs are sampled on the following posedge.
    task automatic drive_update(input logic [XLEN-1:0] pc, input logic taken, input logic [XLEN-1:0] tgt);
        pcE_i          = pc;
        branch_taken_i = taken;
        dirsaltoE_i    = tgt;
        update_i       = 1'b1;
        @(posedge clk_i);
        #1;
        update_i = 1'b0;
    endtask

    task automatic drive_lookup(input logic [XLEN-1:0] pc, input logic [W-1:0] e);
        pcF_i = pc;
        exp_q.push_back(e);
    endtask

    task automatic next_phase();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; pcF_i = '0; pcE_i = '0; update_i = 1'b0; branch_taken_i = 1'b0;
        dirsaltoE_i = '0; desactivar_bp_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        next_phase();
        drive_lookup(32'h100, mk(0, 0, 2'b00, 0, 32'h0));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_lookup: got %h required %h", got, exp_v); end
        next_phase();
    endtask

    task automatic test_alloc();
        drive_update(32'h40, 1'b1, 32'h80);
        drive_lookup(32'h40, mk(0, 1, 2'b10, 1, 32'h80));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL alloc_hit: got %h required %h", got, exp_v); end
        next_phase();
        drive_update(32'h44, 1'b0, 32'h99);
        drive_lookup(32'h44, mk(0, 0, 2'b00, 0, 32'h0));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL alloc_nt_miss: got %h required %h", got, exp_v); end
        next_phase();
    endtask

    task automatic test_saturation();
        repeat (3) drive_update(32'h40, 1'b1, 32'h80);
        drive_lookup(32'h40, mk(0, 1, 2'b11, 1, 32'h80));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL sat_high: got %h required %h", got, exp_v); end
        next_phase();
        drive_update(32'h40, 1'b0, 32'h444);
        drive_lookup(32'h40, mk(0, 1, 2'b10, 1, 32'h80));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL sat_dec1: got %h required %h", got, exp_v); end
        next_phase();
        drive_update(32'h40, 1'b0, 32'h444);
        drive_lookup(32'h40, mk(0, 1, 2'b01, 0, 32'h80));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL sat_dec2: got %h required %h", got, exp_v); end
        next_phase();
        repeat (3) drive_update(32'h40, 1'b0, 32'h444);
        drive_lookup(32'h40, mk(0, 1, 2'b00, 0, 32'h80));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL sat_low: got %h required %h", got, exp_v); end
        next_phase();
    endtask

    task automatic test_alias();
        drive_lookup(32'hC0, mk(0, 0, 2'b00, 0, 32'h80));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL alias_miss: got %h required %h", got, exp_v); end
        next_phase();
        drive_update(32'hC0, 1'b1, 32'h200);
        drive_lookup(32'hC0, mk(0, 1, 2'b10, 1, 32'h200));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL alias_new_hit: got %h required %h", got, exp_v); end
        next_phase();
        drive_lookup(32'h40, mk(0, 0, 2'b00, 0, 32'h200));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL alias_old_miss: got %h required %h", got, exp_v); end
        next_phase();
    endtask

    task automatic test_same_cycle();
        pcE_i = 32'h48; branch_taken_i = 1'b1; dirsaltoE_i = 32'h480; update_i = 1'b1;
        drive_lookup(32'h48, mk(0, 0, 2'b00, 0, 32'h0));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL same_cycle_pre: got %h required %h", got, exp_v); end
        next_phase();
        update_i = 1'b0;
        drive_lookup(32'h48, mk(0, 1, 2'b10, 1, 32'h480));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL same_cycle_post: got %h required %h", got, exp_v); end
        next_phase();
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] pcs [5];
        int n;
        pcs[0] = 32'h10; pcs[1] = 32'h20; pcs[2] = 32'h30; pcs[3] = 32'h50; pcs[4] = 32'h60;
        for (int i = 0; i < 4; i++) drive_update(pcs[i], 1'b1, 32'h1000 + 32'(i));
        drive_lookup(pcs[2], mk(0, 1, 2'b10, 1, 32'h1002));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL flush_pre_hit: got %h required %h", got, exp_v); end
        next_phase();
        flush_i = 1'b1;
        next_phase();
        flush_i = 1'b0;
        drive_lookup(pcs[0], mk(1, 0, 2'b00, 0, 32'h1000));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL flush_lookup_during: got %h required %h", got, exp_v); end
        n = 1;
        while (n < 100) begin
            if (n == 5) begin
                pcE_i = pcs[4]; branch_taken_i = 1'b1; dirsaltoE_i = 32'h6000; update_i = 1'b1;
            end else begin
                update_i = 1'b0;
            end
            @(negedge clk_i);
            if (!busy_o) break;
            n++;
        end
        update_i = 1'b0;
        n_checks++;
        if (n !== 32) begin n_fail++; $display("FAIL flush_busy_cycles: got %0d required %0d", n, 32); end
        next_phase();
        for (int i = 0; i < 5; i++) begin
            drive_lookup(pcs[i], mk(0, 0, 2'b00, 0, (i < 4) ? 32'h1000 + 32'(i) : 32'h0));
            @(negedge clk_i);
            got = observe(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v) begin n_fail++; $display("FAIL flush_post_miss[%0d]: got %h required %h", i, got, exp_v); end
            next_phase();
        end
    endtask

    task automatic test_disable();
        drive_update(32'h70, 1'b1, 32'h700);
        drive_update(32'h70, 1'b1, 32'h700);
        desactivar_bp_i = 1'b1;
        drive_lookup(32'h70, mk(0, 1, 2'b11, 0, 32'h700));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL disable_sel_low: got %h required %h", got, exp_v); end
        next_phase();
        drive_update(32'h70, 1'b0, 32'h0);
        desactivar_bp_i = 1'b0;
        drive_lookup(32'h70, mk(0, 1, 2'b11, 1, 32'h700));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL disable_frozen: got %h required %h", got, exp_v); end
        next_phase();
    endtask

    task automatic test_reset_mid_flush();
        int n;
        flush_i = 1'b1;
        next_phase();
        flush_i = 1'b0;
        n = 0;
        while (n < 10 && busy_o) begin
            @(negedge clk_i);
            n++;
        end
        reset_i = 1'b0;
        #1;
        drive_lookup(32'h70, mk(0, 0, 2'b00, 0, 32'h0));
        #1;
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_mid_flush: got %h required %h", got, exp_v); end
        @(negedge clk_i);
        reset_i = 1'b1;
        next_phase();
        drive_lookup(32'h40, mk(0, 0, 2'b00, 0, 32'h0));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_post_release: got %h required %h", got, exp_v); end
        next_phase();
        drive_update(32'h40, 1'b1, 32'h84);
        drive_lookup(32'h40, mk(0, 1, 2'b10, 1, 32'h84));
        @(negedge clk_i);
        got = observe(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_then_alloc: got %h required %h", got, exp_v); end
        next_phase();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alloc();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_flush();
        test_disable();
        test_reset_mid_flush();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry 2-bit saturating counters, valid bits and a sequenced flush. It sits between the fetch (F) and execute (E) stages. It answers combinational lookups for pcF_i and trains itself from resolved branches in E. Counter state lives inside the block, so the pipeline no longer carries the old prediction down to E.

## Interface
- ENTRIES, 32, number of entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- XLEN, 32, address/target width
- IDX_LSB, 2, lowest PC bit used for the index; tag = pc[XLEN-1 : IDX_LSB+IDX_W]
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-low reset
- pcF_i  in  XLEN  fetch PC for lookup
- pcE_i  in  XLEN  PC of branch resolved in E
- update_i  in  1  a branch resolved in E this cycle
- branch_taken_i  in  1  resolved direction
- dirsaltoE_i  in  XLEN  resolved branch target
- desactivar_bp_i  in  1  predictor disabled
- flush_i  in  1  start invalidate-all sequence (pulse)
- dirobjetivoF_o  out  XLEN  predicted target
- prediccion_o  out  2  counter of the looked-up entry
- hit_o  out  1  valid entry with matching tag
- sel_mux_pred_o  out  1  redirect fetch to dirobjetivoF_o
- busy_o  out  1  flush in progress

## Operation
- Lookup (combinational):
  - idxF = pcF_i[IDX_LSB +: IDX_W].
  - hit_o = valid[idxF] & (tag[idxF] == tagF) & (state == IDLE).
  - prediccion_o = hit_o ? ctr[idxF] : 2'b00.
  - dirobjetivoF_o = target[idxF], unqualified.
  - sel_mux_pred_o = hit_o & prediccion_o[1] & ~desactivar_bp_i.
- Update: occurs when update_i & ~desactivar_bp_i & state==IDLE. idxE and tagE are taken from pcE_i.
  - Hit in E: ctr saturating +1 if taken, −1 if not taken (11 stays 11, 00 stays 00). If taken, target ← dirsaltoE_i. If not taken, target is unchanged.
  - Miss and taken: allocate. valid ← 1, tag ← tagE, target ← dirsaltoE_i, ctr ← 2'b10. This overwrites any aliasing entry.
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- FSM states: IDLE, FLUSH.
  - IDLE → FLUSH on flush_i. The flush counter loads 0.
  - In FLUSH, valid[cnt] ← 0 and cnt++ each cycle. Return to IDLE after the cycle that clears entry ENTRIES−1.
  - flush_i during FLUSH is ignored. Updates during FLUSH are dropped. Lookups miss.
  - cnt is IDX_W bits; wrap-around at the last entry ends the sequence.
- Reset (async assert, any state):
  - state IDLE, cnt 0, busy_o 0.
  - all valid 0, all ctr 2'b01, all tag/target 0.
  - Outputs therefore reset to hit_o 0, prediccion_o 00, sel_mux_pred_o 0, dirobjetivoF_o 0.
  - Reset mid-flush aborts the flush.
- desactivar_bp_i forces sel_mux_pred_o low and freezes training. hit_o and prediccion_o still report table contents.

## Timing
- Lookup latency 0 cycles (combinational from pcF_i).
- An update sampled on edge N is visible to lookups from cycle N+1.
- flush_i sampled at edge N: busy_o is high from N+1 for exactly ENTRIES cycles.
- The cycle in which flush_i is asserted still behaves as IDLE, including lookups and updates.
- Reset deassertion: the first active edge after reset_i rises may accept an update.

## Structure
- Package bp_pkg holds:
  - ctr_t (logic [1:0]) with constants SNT=00, WNT=01, WT=10, ST=11.
  - CTR_RESET=WNT and CTR_ALLOC=WT.
  - bp_state_t enum {IDLE, FLUSH}.
- Sub-module sat_counter_next: combinational, (ctr_t, taken) → ctr_t saturating next value. It is instantiated once on the E path.
- Storage is flop arrays: valid, tag, target, ctr, indexed by IDX_W.

## Test plan
All scenarios use ENTRIES=32, IDX_LSB=2.
- Reset: hold reset_i=0, then release; lookup pcF=0x100 → hit_o=0, prediccion_o=00, sel_mux_pred_o=0, busy_o=0.
- Allocation:
  - Update pcE=0x40, taken, target 0x80 → next cycle pcF=0x40 gives hit_o=1, prediccion_o=10, sel=1, dirobjetivoF_o=0x80.
  - Not-taken update at 0x44 → pcF=0x44 hit_o=0.
- Saturation:
  - Three further taken updates at 0x40 → prediccion_o=11.
  - Two not-taken updates → 01, sel=0, hit_o=1, target still 0x80.
- Aliasing: with 0x40 allocated, lookup 0xC0 (same idx 16, different tag) → hit_o=0. Taken update at 0xC0 target 0x200 → 0xC0 hits and 0x40 misses.
- Flush:
  - Allocate 4 entries and pulse flush_i → busy_o high for 32 cycles.
  - A taken update at cycle 5 of the flush is dropped.
  - After busy_o falls, all 4 PCs and the dropped PC miss.
- Disable/reset: with an 11 entry hit, desactivar_bp_i=1 → sel=0, hit_o=1, and a not-taken update leaves the counter at 11. reset_i=0 at flush cycle 10 → busy_o=0 immediately and all lookups miss.
